// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: fetch FSM encoding,
// reset-vector default and small PC arithmetic helpers.
package fetch_stage_pkg;

    // Architectural boot vector (first PC fetched after reset).
    localparam logic [31:0] PC_RESET_DEFAULT = 32'hBFC0_0000;

    // Legacy-compatible raw encodings for the fetch FSM.
    localparam logic [1:0] FS_REQ_ENC  = 2'd0;
    localparam logic [1:0] FS_WAIT_ENC = 2'd1;
    localparam logic [1:0] FS_HOLD_ENC = 2'd2;

    // REQ  : request driven on the instruction bus
    // WAIT : address accepted, instruction word still outstanding
    // HOLD : instruction held in the buffer until decode takes it
    typedef enum logic [1:0] {
        REQ  = FS_REQ_ENC,
        WAIT = FS_WAIT_ENC,
        HOLD = FS_HOLD_ENC
    } fetch_state_t;

    // Sequential PC; wraps modulo 2^32, carry out is dropped.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc_val);
        return pc_val + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_select.sv
// Next-PC selection for the fetch stage. A redirect arriving in the same
// cycle as the handoff has highest priority, then a redirect latched
// earlier (pending), otherwise fall through to the sequential PC.
module pc_select
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        pend_valid,
    input  logic [31:0] pend_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] next_pc
);

    // Priority mux: live redirect > pending target > pc + 4.
    always_comb begin
        next_pc = 32'd0;
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (pend_valid) begin
            next_pc = pend_pc;
        end else begin
            next_pc = pc_plus4(pc);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Issues one instruction-bus request at a time,
// buffers the returned word and holds it for decode. Taken branches are
// resolved in decode; the instruction already in flight or held when the
// redirect arrives is the delay slot and is always delivered.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stallD,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic        validF
);

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;

    logic [31:0] pc_r;
    logic [31:0] next_pc_s;
    logic        pend_valid_r;
    logic [31:0] pend_pc_r;

    logic        ireq_valid_r;
    logic [31:0] instr_r;
    logic [31:0] pc_f_r;
    logic        valid_f_r;

    logic        handoff_s;
    logic        take_data_s;

    // Next-state logic; handoff and data capture strobes fall out of it.
    // The request is qualified by ireq_valid_r so the cycle right after
    // reset (REQ with no request yet on the bus) cannot advance the FSM.
    always_comb begin
        state_nxt_s = state_r;
        handoff_s   = 1'b0;
        take_data_s = 1'b0;
        case (state_r)
            REQ: begin
                if (ireq_valid_r && iresp_addr_ok) begin
                    if (iresp_data_ok) begin
                        state_nxt_s = HOLD;
                        take_data_s = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (iresp_data_ok) begin
                    state_nxt_s = HOLD;
                    take_data_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            HOLD: begin
                if (!stallD) begin
                    state_nxt_s = REQ;
                    handoff_s   = 1'b1;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = REQ;
            end
        endcase
    end

    pc_select u_pc_select (
        .pc             (pc_r),
        .pend_valid     (pend_valid_r),
        .pend_pc        (pend_pc_r),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (next_pc_s)
    );

    // FSM state and registered request-valid (high exactly while in REQ,
    // except the first cycle out of reset).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= REQ;
            ireq_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ireq_valid_r <= (state_nxt_s == REQ);
        end
    end

    // Fetch PC: advances only on handoff, so the bus address stays stable
    // from request issue until the bus accepts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= PC_RESET;
        end else if (handoff_s) begin
            pc_r <= next_pc_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Pending redirect target: a redirect seen outside a handoff cycle is
    // remembered (latest wins) and consumed by the next handoff.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_r <= 1'b0;
            pend_pc_r    <= 32'd0;
        end else if (handoff_s) begin
            pend_valid_r <= 1'b0;
            pend_pc_r    <= pend_pc_r;
        end else if (redirect_valid) begin
            pend_valid_r <= 1'b1;
            pend_pc_r    <= redirect_pc;
        end else begin
            pend_valid_r <= pend_valid_r;
            pend_pc_r    <= pend_pc_r;
        end
    end

    // Instruction buffer toward decode: loaded when the word returns and
    // left untouched while decode stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r   <= 32'd0;
            pc_f_r    <= 32'd0;
            valid_f_r <= 1'b0;
        end else begin
            valid_f_r <= (state_nxt_s == HOLD);
            if (take_data_s) begin
                instr_r <= iresp_data;
                pc_f_r  <= pc_r;
            end else begin
                instr_r <= instr_r;
                pc_f_r  <= pc_f_r;
            end
        end
    end

    assign ireq_valid = ireq_valid_r;
    assign ireq_addr  = pc_r;
    assign instrF     = instr_r;
    assign pcF        = pc_f_r;
    assign validF     = valid_f_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. Inputs change 1 time unit
// after each rising edge; outputs are sampled at the same point.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stallD;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic        validF;

    int pass_cnt;
    int total_cnt;

    fetch_stage #(.PC_RESET(32'hBFC0_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stallD         (stallD),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instrF         (instrF),
        .pcF            (pcF),
        .validF         (validF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total_cnt++; if (ireq_valid !== 1'b0) $display("FAIL rst_ireq_valid got %h exp 0", ireq_valid); else pass_cnt++;
        total_cnt++; if (validF !== 1'b0) $display("FAIL rst_validF got %h exp 0", validF); else pass_cnt++;
        total_cnt++; if (instrF !== 32'h0) $display("FAIL rst_instrF got %h exp 00000000", instrF); else pass_cnt++;
        total_cnt++; if (pcF !== 32'h0) $display("FAIL rst_pcF got %h exp 00000000", pcF); else pass_cnt++;
        reset = 1'b0;
        step();
        total_cnt++; if (ireq_valid !== 1'b1) $display("FAIL rel_ireq_valid got %h exp 1", ireq_valid); else pass_cnt++;
        total_cnt++; if (ireq_addr !== 32'hBFC0_0000) $display("FAIL rel_ireq_addr got %h exp bfc00000", ireq_addr); else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h1111_0001;
        step();
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        total_cnt++; if (validF !== 1'b1) $display("FAIL same_validF got %h exp 1", validF); else pass_cnt++;
        total_cnt++; if (pcF !== 32'hBFC0_0000) $display("FAIL same_pcF got %h exp bfc00000", pcF); else pass_cnt++;
        total_cnt++; if (instrF !== 32'h1111_0001) $display("FAIL same_instrF got %h exp 11110001", instrF); else pass_cnt++;
        total_cnt++; if (ireq_valid !== 1'b0) $display("FAIL same_no_req got %h exp 0", ireq_valid); else pass_cnt++;
        step();
        total_cnt++; if (validF !== 1'b0) $display("FAIL same_validF_drop got %h exp 0", validF); else pass_cnt++;
        total_cnt++; if (ireq_valid !== 1'b1) $display("FAIL same_next_req got %h exp 1", ireq_valid); else pass_cnt++;
        total_cnt++; if (ireq_addr !== 32'hBFC0_0004) $display("FAIL same_next_addr got %h exp bfc00004", ireq_addr); else pass_cnt++;
    endtask

    task automatic test_wait_latency();
        iresp_addr_ok = 1'b1;                         // cycle 1
        step();                                       // cycle 2
        iresp_addr_ok = 1'b0;
        total_cnt++; if (ireq_valid !== 1'b0) $display("FAIL wait_c2_req got %h exp 0", ireq_valid); else pass_cnt++;
        step();                                       // cycle 3
        total_cnt++; if (ireq_valid !== 1'b0) $display("FAIL wait_c3_req got %h exp 0", ireq_valid); else pass_cnt++;
        total_cnt++; if (validF !== 1'b0) $display("FAIL wait_c3_validF got %h exp 0", validF); else pass_cnt++;
        step();                                       // cycle 4
        total_cnt++; if (ireq_valid !== 1'b0) $display("FAIL wait_c4_req got %h exp 0", ireq_valid); else pass_cnt++;
        iresp_data_ok = 1'b1; iresp_data = 32'h2222_0004;
        step();                                       // cycle 5
        iresp_data_ok = 1'b0;
        total_cnt++; if (validF !== 1'b1) $display("FAIL wait_c5_validF got %h exp 1", validF); else pass_cnt++;
        total_cnt++; if (instrF !== 32'h2222_0004) $display("FAIL wait_instrF got %h exp 22220004", instrF); else pass_cnt++;
        total_cnt++; if (pcF !== 32'hBFC0_0004) $display("FAIL wait_pcF got %h exp bfc00004", pcF); else pass_cnt++;
    endtask

    // Entered while HOLD of BFC00004 is showing.
    task automatic test_stall();
        stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (validF !== 1'b1) $display("FAIL stall_validF[%0d] got %h exp 1", i, validF); else pass_cnt++;
            total_cnt++; if (instrF !== 32'h2222_0004) $display("FAIL stall_instrF[%0d] got %h exp 22220004", i, instrF); else pass_cnt++;
            total_cnt++; if (pcF !== 32'hBFC0_0004) $display("FAIL stall_pcF[%0d] got %h exp bfc00004", i, pcF); else pass_cnt++;
            total_cnt++; if (ireq_valid !== 1'b0) $display("FAIL stall_no_req[%0d] got %h exp 0", i, ireq_valid); else pass_cnt++;
        end
        stallD = 1'b0;
        step();
        total_cnt++; if (ireq_valid !== 1'b1) $display("FAIL stall_rel_req got %h exp 1", ireq_valid); else pass_cnt++;
        total_cnt++; if (ireq_addr !== 32'hBFC0_0008) $display("FAIL stall_rel_addr got %h exp bfc00008", ireq_addr); else pass_cnt++;
    endtask

    task automatic test_redirect_wait();
        iresp_addr_ok = 1'b1;
        step();                                       // WAIT on BFC00008
        iresp_addr_ok = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0100;
        step();
        redirect_valid = 1'b0;
        step();
        iresp_data_ok = 1'b1; iresp_data = 32'h3333_0008;
        step();
        iresp_data_ok = 1'b0;
        total_cnt++; if (validF !== 1'b1) $display("FAIL rdw_validF got %h exp 1", validF); else pass_cnt++;
        total_cnt++; if (pcF !== 32'hBFC0_0008) $display("FAIL rdw_pcF got %h exp bfc00008", pcF); else pass_cnt++;
        total_cnt++; if (instrF !== 32'h3333_0008) $display("FAIL rdw_instrF got %h exp 33330008", instrF); else pass_cnt++;
        step();
        total_cnt++; if (ireq_valid !== 1'b1) $display("FAIL rdw_req got %h exp 1", ireq_valid); else pass_cnt++;
        total_cnt++; if (ireq_addr !== 32'hBFC0_0100) $display("FAIL rdw_addr got %h exp bfc00100", ireq_addr); else pass_cnt++;
    endtask

    task automatic test_two_redirects();
        // Fetch of BFC00100; first redirect while in REQ, second while HOLD stalls.
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h4444_0100;
        redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0100;
        step();
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        stallD = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0200;
        step();
        redirect_valid = 1'b0;
        total_cnt++; if (pcF !== 32'hBFC0_0100) $display("FAIL two_pcF got %h exp bfc00100", pcF); else pass_cnt++;
        total_cnt++; if (validF !== 1'b1) $display("FAIL two_validF got %h exp 1", validF); else pass_cnt++;
        stallD = 1'b0;
        step();
        total_cnt++; if (ireq_addr !== 32'hBFC0_0200) $display("FAIL two_addr got %h exp bfc00200", ireq_addr); else pass_cnt++;

        // Pending target set, then a live redirect in the handoff cycle wins.
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h5555_0200;
        step();
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        stallD = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0500;
        step();
        stallD = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0600;
        step();
        redirect_valid = 1'b0;
        total_cnt++; if (ireq_addr !== 32'hBFC0_0600) $display("FAIL hand_rd_addr got %h exp bfc00600", ireq_addr); else pass_cnt++;

        // Pending cleared by that handoff: next fetch is sequential.
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h6666_0600;
        step();
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        step();
        total_cnt++; if (ireq_addr !== 32'hBFC0_0604) $display("FAIL pend_clr_addr got %h exp bfc00604", ireq_addr); else pass_cnt++;
    endtask

    task automatic test_wrap();
        // Redirect to the top word, then pc+4 must wrap to zero.
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h7777_0604;
        step();
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        total_cnt++; if (ireq_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top_addr got %h exp fffffffc", ireq_addr); else pass_cnt++;
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h8888_FFFC;
        step();
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        total_cnt++; if (pcF !== 32'hFFFF_FFFC) $display("FAIL wrap_pcF got %h exp fffffffc", pcF); else pass_cnt++;
        step();
        total_cnt++; if (ireq_addr !== 32'h0000_0000) $display("FAIL wrap_addr got %h exp 00000000", ireq_addr); else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        iresp_addr_ok = 1'b1;
        step();                                       // WAIT
        iresp_addr_ok = 1'b0;
        total_cnt++; if (ireq_valid !== 1'b0) $display("FAIL rw_wait_req got %h exp 0", ireq_valid); else pass_cnt++;
        reset = 1'b1;
        step();
        total_cnt++; if (validF !== 1'b0) $display("FAIL rw_validF got %h exp 0", validF); else pass_cnt++;
        total_cnt++; if (ireq_valid !== 1'b0) $display("FAIL rw_req got %h exp 0", ireq_valid); else pass_cnt++;
        total_cnt++; if (pcF !== 32'h0) $display("FAIL rw_pcF got %h exp 00000000", pcF); else pass_cnt++;
        reset = 1'b0;
        step();
        total_cnt++; if (ireq_valid !== 1'b1) $display("FAIL rw_rel_req got %h exp 1", ireq_valid); else pass_cnt++;
        total_cnt++; if (ireq_addr !== 32'hBFC0_0000) $display("FAIL rw_rel_addr got %h exp bfc00000", ireq_addr); else pass_cnt++;
        iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h9999_0000;
        step();
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
        total_cnt++; if (pcF !== 32'hBFC0_0000) $display("FAIL rw_refetch_pcF got %h exp bfc00000", pcF); else pass_cnt++;
        total_cnt++; if (instrF !== 32'h9999_0000) $display("FAIL rw_refetch_instrF got %h exp 99990000", instrF); else pass_cnt++;
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        reset          = 1'b1;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'h0;
        stallD         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        test_reset();
        test_same_cycle();
        test_wait_latency();
        test_stall();
        test_redirect_wait();
        test_two_redirects();
        test_wrap();
        test_reset_in_wait();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'hBFC0_0000, meaning PC fetched first after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ireq_valid  output  1  instruction-bus request valid.
REQ-005 SHALL have port ireq_addr  output  32  instruction-bus request address.
REQ-006 SHALL have port iresp_addr_ok  input  1  bus accepted current request.
REQ-007 SHALL have port iresp_data_ok  input  1  bus returns instruction word.
REQ-008 SHALL have port iresp_data  input  32  returned instruction word.
REQ-009 SHALL have port stallD  input  1  decode cannot accept an instruction this cycle.
REQ-010 SHALL have port redirect_valid  input  1  one-cycle pulse: decode resolved a taken branch/jump.
REQ-011 SHALL have port redirect_pc  input  32  target of that branch/jump.
REQ-012 SHALL have port instrF  output  32  instruction handed to decode.
REQ-013 SHALL have port pcF  output  32  PC of instrF.
REQ-014 SHALL have port validF  output  1  instrF/pcF valid this cycle.

Function
REQ-015 SHALL run FSM states REQ (request driven), WAIT (address accepted, data outstanding), HOLD (instruction held for decode).
REQ-016 SHALL drive ireq_valid=1 only in REQ, ireq_addr=pc, both stable until iresp_addr_ok.
REQ-017 SHALL transition REQ->WAIT on addr_ok without data_ok; REQ->HOLD on addr_ok with data_ok in the same cycle; WAIT->HOLD on data_ok.
REQ-018 SHALL capture iresp_data into the instruction buffer on data_ok; validF=1 only in HOLD; instrF/pcF come from registers, never combinationally from the bus.
REQ-019 SHALL hand off when HOLD and !stallD: next cycle pc=next_pc, state=REQ; minimum latency request-to-handoff is 1 cycle (addr_ok and data_ok together).
REQ-020 SHALL remain in HOLD with instrF/pcF unchanged while stallD=1.
REQ-021 SHALL use next_pc = redirect_pc if redirect_valid in the handoff cycle, else pending target if set, else pc+4 (32-bit wrap, no carry).
REQ-022 SHALL treat the instruction in flight or held at redirect time as the delay slot and always deliver it; none is discarded.
REQ-023 SHALL latch redirect_pc into a pending register on redirect_valid when no handoff occurs that cycle; clear it on the next handoff.
REQ-024 SHALL let a new redirect_valid overwrite an existing pending target (latest wins).
REQ-025 SHALL ignore stallD and redirect_valid for FSM transitions outside HOLD, except pending capture per REQ-023.
REQ-026 SHALL not issue a new request while a data_ok is outstanding (at most one outstanding transaction).

Reset
REQ-027 SHALL on reset set pc=PC_RESET, state=REQ, pending cleared, instrF=0, pcF=0, validF=0, ireq_valid=0 in the reset cycle.
REQ-028 SHALL, on reset in WAIT, drop the outstanding transaction; bus guarantees no data_ok after reset, and fetch restarts at PC_RESET.

Structure
REQ-029 SHALL place fetch_state_t enum (REQ/WAIT/HOLD) and PC_RESET default constant in the shared CPU package.
REQ-030 SHALL implement next_pc selection in one sub-module, pc_select (combinational: pc, pending, redirect -> next_pc).

Verification
REQ-031 SHALL cover reset release, bus answers addr_ok+data_ok same cycle, stallD=0 -> ireq_addr BFC00000, then BFC00004 one cycle after handoff; validF pulses with pcF=BFC00000.
REQ-032 SHALL cover addr_ok at cycle 1, data_ok at cycle 4 -> ireq_valid low cycles 2-4, validF rises cycle 5, instrF=returned word.
REQ-033 SHALL cover HOLD with stallD=1 for 3 cycles -> instrF/pcF constant, no new request; after release next request at pc+4.
REQ-034 SHALL cover redirect_valid (redirect_pc=BFC00100) while fetch of BFC00008 in WAIT -> BFC00008 delivered, next request BFC00100.
REQ-035 SHALL cover two redirects (BFC00100 then BFC00200) before handoff -> next request BFC00200; redirect with handoff same cycle -> request redirect_pc directly.
REQ-036 SHALL cover reset asserted in WAIT -> next cycle validF=0, request BFC00000 after reset release.
